riscv_fetch_fifo: RTL and testbench

Instruction prefetch unit that sits directly upstream of the IF stage. It issues word-aligned requests on the instruction memory interface (req/gnt/rvalid) and buffers returned words in a small FIFO. It presents the next instruction, 16- or 32-bit and halfword-aligned, to IF with a valid/ready handshake. Branches flush the FIFO and abort any in-flight transaction.

---
 rtl/riscv_fetch_fifo.sv | 210 +++++++++++++++++++++
 tb/tb_riscv_fetch_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_fifo.sv
// Instruction prefetch buffer: issues word fetches on a req/gnt/rvalid bus,
// queues returned words and realigns them into 16/32-bit instructions for IF.
module riscv_fetch_fifo #(
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        busy_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID,
    WAIT_ABORTED
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [31:0]   abort_addr_q, abort_addr_d;
  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   mem_q [DEPTH];

  logic [PW-1:0] rd_ptr_inc, wr_ptr_inc;
  logic [31:0]   w0, w1;
  logic          have_w0, have_w1;
  logic          valid_raw;
  logic [31:0]   rdata_raw;
  logic          is_rvc;
  logic          fire, pop, push;
  logic          outstanding;
  logic [CW:0]   free_w;
  logic          allowed;
  logic [31:0]   tgt_addr;
  logic [31:0]   abort_tgt;
  logic [31:0]   next_fetch;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_ptr_inc = ptr_inc(rd_ptr_q);
  assign wr_ptr_inc = ptr_inc(wr_ptr_q);
  assign w0         = mem_q[rd_ptr_q];
  assign w1         = mem_q[rd_ptr_inc];
  assign have_w0    = (count_q != '0);
  assign have_w1    = (count_q > CW'(1));

  // Head-of-queue realignment: a halfword PC straddles W0 and W1 unless the upper half is compressed.
  always_comb begin
    valid_raw = 1'b0;
    rdata_raw = '0;
    if (!pc_q[1]) begin
      valid_raw = have_w0;
      rdata_raw = w0;
    end else if (w0[17:16] != 2'b11) begin
      valid_raw = have_w0;
      rdata_raw = {16'h0000, w0[31:16]};
    end else begin
      valid_raw = have_w1;
      rdata_raw = {w1[15:0], w0[31:16]};
    end
  end

  assign valid_o = valid_raw && !branch_i;
  assign rdata_o = valid_o ? rdata_raw : 32'h0;
  assign addr_o  = pc_q;
  assign is_rvc  = (rdata_raw[1:0] != 2'b11);
  assign fire    = valid_o && ready_i;
  assign pop     = fire && (pc_q[1] || !is_rvc);

  always_comb begin
    pc_d = pc_q;
    if (branch_i) begin
      pc_d = addr_i;
    end else if (fire) begin
      pc_d = pc_q + (is_rvc ? 32'd2 : 32'd4);
    end
  end

  // Credit check: free slots after this cycle's pop must exceed transactions still in flight.
  assign outstanding = (state_q == WAIT_RVALID) || (state_q == WAIT_ABORTED);
  assign free_w      = (CW + 1)'(DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, pop};
  assign allowed     = req_i && (free_w > {{CW{1'b0}}, outstanding});
  assign tgt_addr    = {addr_i[31:2], 2'b00};
  assign abort_tgt   = branch_i ? tgt_addr : abort_addr_q;
  assign next_fetch  = fetch_addr_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    abort_addr_d = abort_addr_q;
    instr_req_o  = 1'b0;
    instr_addr_o = fetch_addr_q;
    push         = 1'b0;
    case (state_q)
      IDLE: begin
        if (branch_i || allowed) begin
          instr_req_o  = 1'b1;
          instr_addr_o = branch_i ? tgt_addr : fetch_addr_q;
          fetch_addr_d = instr_addr_o;
          state_d      = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        instr_req_o  = 1'b1;
        instr_addr_o = branch_i ? tgt_addr : fetch_addr_q;
        fetch_addr_d = instr_addr_o;
        if (instr_gnt_i) begin
          state_d = WAIT_RVALID;
        end
      end
      WAIT_RVALID: begin
        if (instr_rvalid_i) begin
          if (branch_i) begin
            instr_req_o  = 1'b1;
            instr_addr_o = tgt_addr;
            fetch_addr_d = tgt_addr;
            state_d      = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
          end else begin
            push         = 1'b1;
            fetch_addr_d = next_fetch;
            instr_addr_o = next_fetch;
            if (allowed) begin
              instr_req_o = 1'b1;
              state_d     = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
            end else begin
              state_d = IDLE;
            end
          end
        end else if (branch_i) begin
          abort_addr_d = tgt_addr;
          state_d      = WAIT_ABORTED;
        end
      end
      WAIT_ABORTED: begin
        abort_addr_d = abort_tgt;
        if (instr_rvalid_i) begin
          instr_req_o  = 1'b1;
          instr_addr_o = abort_tgt;
          fetch_addr_d = abort_tgt;
          state_d      = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE) || instr_req_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      abort_addr_q <= '0;
      pc_q         <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      abort_addr_q <= abort_addr_d;
      pc_q         <= pc_d;
      if (branch_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_inc;
        if (pop)  rd_ptr_q <= rd_ptr_inc;
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: rdata_o is masked whenever the queue cannot supply it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= instr_rdata_i;
    end
  end

  a_gnt_without_req : assert property (@(posedge clk) disable iff (!rst_n)
    instr_gnt_i |-> instr_req_o);
  a_rvalid_in_idle : assert property (@(posedge clk) disable iff (!rst_n)
    !(instr_rvalid_i && (state_q == IDLE)));
  a_push_while_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == CW'(DEPTH))));
  a_branch_misaligned : assert property (@(posedge clk) disable iff (!rst_n)
    branch_i |-> !addr_i[0]);

endmodule

// File: tb/tb_riscv_fetch_fifo.sv
// Directed bench for riscv_fetch_fifo: drives the memory side cycle by cycle
// and compares against hand-derived values.
module tb_riscv_fetch_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i, branch_i, ready_i;
  logic [31:0] addr_i;
  logic        valid_o;
  logic [31:0] rdata_o, addr_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i, instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_fetch_fifo #(.DEPTH(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .branch_i      (branch_i),
    .addr_i        (addr_i),
    .ready_i       (ready_i),
    .valid_o       (valid_o),
    .rdata_o       (rdata_o),
    .addr_o        (addr_o),
    .instr_req_o   (instr_req_o),
    .instr_addr_o  (instr_addr_o),
    .instr_gnt_i   (instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i (instr_rdata_i),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  // Apply one cycle's inputs, then let the combinational outputs settle before checking.
  task automatic drive(input logic br, input logic [31:0] ba, input logic gnt,
                       input logic rv, input logic [31:0] rd, input logic rdy);
    branch_i       = br;
    addr_i         = ba;
    instr_gnt_i    = gnt;
    instr_rvalid_i = rv;
    instr_rdata_i  = rd;
    ready_i        = rdy;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    check("rst valid_o", 32'(valid_o), 32'd0);
    check("rst rdata_o", rdata_o, 32'h0);
    check("rst addr_o", addr_o, 32'h0);
    check("rst instr_req_o", 32'(instr_req_o), 32'd0);
    check("rst instr_addr_o", instr_addr_o, 32'h0);
    check("rst busy_o", 32'(busy_o), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Branch to 0x80 and fill the buffer
    req_i = 1'b1;
    drive(1, 32'h80, 0, 0, 0, 0);
    check("br80 instr_req_o", 32'(instr_req_o), 32'd1);
    check("br80 instr_addr_o", instr_addr_o, 32'h80);
    check("br80 valid_o", 32'(valid_o), 32'd0);
    step();
    drive(0, 0, 1, 0, 0, 0);
    check("gnt80 instr_addr_o", instr_addr_o, 32'h80);
    step();
    drive(0, 0, 1, 1, 32'h0041_0113, 0);
    check("b2b instr_addr_o", instr_addr_o, 32'h84);
    check("b2b instr_req_o", 32'(instr_req_o), 32'd1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("w80 valid_o", 32'(valid_o), 32'd1);
    check("w80 rdata_o", rdata_o, 32'h0041_0113);
    check("w80 addr_o", addr_o, 32'h80);
    step();
    drive(0, 0, 1, 1, 32'h8082_4501, 0);
    check("b2b2 instr_addr_o", instr_addr_o, 32'h88);
    step();
    drive(0, 0, 0, 1, 32'h0000_0297, 0);
    check("fill3 instr_req_o", 32'(instr_req_o), 32'd0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("full instr_req_o", 32'(instr_req_o), 32'd0);
    check("full busy_o", 32'(busy_o), 32'd0);
    step();

    // Drain: 32-bit, then two compressed halves of one word
    req_i = 1'b0;
    drive(0, 0, 0, 0, 0, 1);
    check("pop80 addr_o", addr_o, 32'h80);
    step();
    drive(0, 0, 0, 0, 0, 1);
    check("c84 rdata_o", rdata_o, 32'h8082_4501);
    check("c84 addr_o", addr_o, 32'h84);
    step();
    drive(0, 0, 0, 0, 0, 1);
    check("c86 rdata_o", rdata_o, 32'h0000_8082);
    check("c86 addr_o", addr_o, 32'h86);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("w88 rdata_o", rdata_o, 32'h0000_0297);
    check("w88 addr_o", addr_o, 32'h88);
    step();

    // Branch to 0x102: compressed upper half usable from W0 alone
    req_i = 1'b1;
    drive(1, 32'h102, 1, 0, 0, 0);
    check("br102 instr_addr_o", instr_addr_o, 32'h100);
    check("br102 valid_o", 32'(valid_o), 32'd0);
    step();
    drive(0, 0, 0, 1, 32'h4501_0000, 0);
    check("b2b104 instr_addr_o", instr_addr_o, 32'h104);
    step();
    drive(0, 0, 0, 0, 0, 1);
    check("c102 valid_o", 32'(valid_o), 32'd1);
    check("c102 rdata_o", rdata_o, 32'h0000_4501);
    check("c102 addr_o", addr_o, 32'h102);
    step();
    drive(0, 0, 1, 0, 0, 0);
    check("pop102 addr_o", addr_o, 32'h104);
    check("pop102 valid_o", 32'(valid_o), 32'd0);
    step();

    // Branch to 0x300 while 0x104 is in flight
    drive(1, 32'h300, 0, 0, 0, 0);
    check("abort instr_req_o", 32'(instr_req_o), 32'd0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("aborted instr_req_o", 32'(instr_req_o), 32'd0);
    check("aborted busy_o", 32'(busy_o), 32'd1);
    step();
    drive(0, 0, 1, 1, 32'hDEAD_BEEF, 0);
    check("drop instr_req_o", 32'(instr_req_o), 32'd1);
    check("drop instr_addr_o", instr_addr_o, 32'h300);
    check("drop valid_o", 32'(valid_o), 32'd0);
    step();
    drive(0, 0, 0, 1, 32'h0000_0513, 0);
    step();

    // Grant withheld; branch to 0x400 in the second cycle of the wait
    drive(0, 0, 0, 0, 0, 0);
    check("w300 rdata_o", rdata_o, 32'h0000_0513);
    check("w300 addr_o", addr_o, 32'h300);
    check("gw1 instr_addr_o", instr_addr_o, 32'h304);
    step();
    drive(1, 32'h400, 0, 0, 0, 0);
    check("gw2 instr_addr_o", instr_addr_o, 32'h400);
    check("gw2 instr_req_o", 32'(instr_req_o), 32'd1);
    step();
    for (int i = 3; i <= 5; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      check($sformatf("gw%0d instr_addr_o", i), instr_addr_o, 32'h400);
      check($sformatf("gw%0d instr_req_o", i), 32'(instr_req_o), 32'd1);
      step();
    end
    drive(0, 0, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 32'h0000_0093, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("w400 rdata_o", rdata_o, 32'h0000_0093);
    check("w400 addr_o", addr_o, 32'h400);

    // Branch to 0x202: uncompressed instruction straddles two words
    drive(1, 32'h202, 1, 0, 0, 0);
    check("br202 instr_addr_o", instr_addr_o, 32'h200);
    step();
    drive(0, 0, 0, 1, 32'hFFFF_0000, 0);
    step();
    drive(0, 0, 1, 0, 0, 0);
    check("split wait valid_o", 32'(valid_o), 32'd0);
    step();
    drive(0, 0, 0, 1, 32'h0000_1234, 0);
    step();
    drive(0, 0, 0, 0, 0, 1);
    check("split valid_o", 32'(valid_o), 32'd1);
    check("split rdata_o", rdata_o, 32'h1234_FFFF);
    check("split addr_o", addr_o, 32'h202);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("pop202 addr_o", addr_o, 32'h206);
    check("c206 valid_o", 32'(valid_o), 32'd1);
    check("c206 rdata_o", rdata_o, 32'h0000_0000);

    // Asynchronous reset with two words buffered and a read in flight
    drive(0, 0, 1, 0, 0, 0);
    step();
    drive(0, 0, 1, 1, 32'h1111_1111, 0);
    check("pre-rst busy_o", 32'(busy_o), 32'd1);
    step();
    req_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    check("pre-rst valid_o", 32'(valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst valid_o", 32'(valid_o), 32'd0);
    check("arst rdata_o", rdata_o, 32'h0);
    check("arst addr_o", addr_o, 32'h0);
    check("arst instr_req_o", 32'(instr_req_o), 32'd0);
    check("arst instr_addr_o", instr_addr_o, 32'h0);
    check("arst busy_o", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("post-rst valid_o", 32'(valid_o), 32'd0);
    check("post-rst busy_o", 32'(busy_o), 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
